// File: rtl/wrr_arb_pkg.sv
// wrr_arb_pkg
// Shared types, constants and helpers for the weighted round-robin arbiter.
//   state_t    : arbiter FSM state (IDLE, GRANT)
//   MAX_N      : largest supported requester count
//   IDX_MAX_W  : index width needed for MAX_N requesters
//   onehot2idx : converts a one-hot vector (zero-extended to MAX_N) to its index
package wrr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_N     = 64;
    localparam int IDX_MAX_W = $clog2(MAX_N);

    // ORing the indices of all set bits gives the index of a one-hot vector,
    // and zero for an all-zero vector, which is what gnt_idx needs when idle.
    function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector: finds the first set request bit
// searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   req   : request vector (N bits)
//   ptr   : highest-priority index
//   found : at least one request bit is set
//   idx   : index of the selected requester (0 when found = 0)
module rr_pick #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] rot;
    int           offset;

    // Rotate so that the ptr position lands on bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + int'(ptr)) % N];
        end
    end

    // Find-first from bit 0 of the rotated vector, then undo the rotation.
    always_comb begin
        found  = 1'b0;
        offset = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end
        idx = found ? IDX_W'((offset + int'(ptr)) % N) : '0;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter
// Weighted round-robin arbiter with a registered valid/ready grant. Each
// winner gets weight+1 consecutive grants, then priority rotates past it.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector, bit i per requester
//   weight    : per-requester burst weight, field i = weight[i*WEIGHT_W +: WEIGHT_W]
//   gnt_ready : consumer accepts the current grant
//   lock      : (only with WRR_LOCK_EN) keeps the current burst going while lock[w]=1
//   gnt       : registered one-hot grant
//   gnt_valid : gnt is non-zero
//   gnt_idx   : binary index of the granted requester, 0 when idle
//   gnt_last  : final grant of the current burst
// Optional feature macro: WRR_LOCK_EN
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  gnt_ready,
`ifdef WRR_LOCK_EN
    input  logic [N-1:0]          lock,
`endif
    output logic [N-1:0]          gnt,
    output logic                  gnt_valid,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic                  gnt_last
);

    state_t              state, state_n;
    logic [N-1:0]        gnt_n;
    logic [WEIGHT_W-1:0] credit, credit_n;
    logic [IDX_W-1:0]    ptr, ptr_n;

    logic [IDX_W-1:0]    cur_idx;
    logic [IDX_W-1:0]    burst_ptr;
    logic [IDX_W-1:0]    pick_ptr;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                req_w;
    logic                lock_w;
    logic                accept;

    logic [WEIGHT_W-1:0] weight_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_weight
        assign weight_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
    end

    assign cur_idx   = IDX_W'(onehot2idx(MAX_N'(gnt)));
    assign req_w     = req[cur_idx];
    assign burst_ptr = (cur_idx == IDX_W'(N - 1)) ? '0 : cur_idx + IDX_W'(1);
    assign accept    = (state == GRANT) && gnt_ready;

`ifdef WRR_LOCK_EN
    assign lock_w = (state == GRANT) && lock[cur_idx];
`else
    assign lock_w = 1'b0;
`endif

    // At a burst end the search starts past the current winner; this is
    // what lets a lone requester wrap around and win again with no bubble.
    assign pick_ptr = (state == GRANT) ? burst_ptr : ptr;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State, grant, credit and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            credit <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            credit <= credit_n;
            ptr    <= ptr_n;
        end
    end

    // Next-state logic: start a burst from IDLE, continue it on accept while
    // credit remains (or lock holds it), otherwise rotate and re-arbitrate.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        credit_n = credit;
        ptr_n    = ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n         = GRANT;
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    credit_n        = weight_arr[pick_idx];
                end
            end
            GRANT: begin
                if (accept) begin
                    if (lock_w) begin
                        credit_n = credit;
                    end else if (!gnt_last) begin
                        credit_n = credit - WEIGHT_W'(1);
                    end else begin
                        ptr_n = burst_ptr;
                        if (pick_found) begin
                            gnt_n           = '0;
                            gnt_n[pick_idx] = 1'b1;
                            credit_n        = weight_arr[pick_idx];
                        end else begin
                            state_n  = IDLE;
                            gnt_n    = '0;
                            credit_n = '0;
                        end
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                credit_n = '0;
            end
        endcase
    end

    // Outputs are derived from the registered grant; gnt_last looks at the
    // live request so a requester that drops early ends its burst.
    always_comb begin
        gnt_valid = (state == GRANT);
        gnt_idx   = cur_idx;
        gnt_last  = gnt_valid && ((credit == '0) || !req_w) && !lock_w;
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter
// Directed self-checking bench for wrr_arbiter with N=4, WEIGHT_W=4.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_wrr_arbiter;

    localparam int N        = 4;
    localparam int WEIGHT_W = 4;
    localparam int IDX_W    = 2;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N*WEIGHT_W-1:0] weight;
    logic                  gnt_ready;
`ifdef WRR_LOCK_EN
    logic [N-1:0]          lock;
`endif
    logic [N-1:0]          gnt;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_last;

    int checks;
    int errors;

    wrr_arbiter #(
        .N        (N),
        .WEIGHT_W (WEIGHT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .weight    (weight),
        .gnt_ready (gnt_ready),
`ifdef WRR_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_last  (gnt_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*WEIGHT_W-1:0] w,
                                 input logic rdy);
        @(negedge clk);
        req       = r;
        weight    = w;
        gnt_ready = rdy;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        req       = '0;
        gnt_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N-1:0] seq1 [5];
    logic [1:0]   seq2_idx [8];
    logic         seq2_last [8];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = '0;
        weight    = '0;
        gnt_ready = 1'b0;
`ifdef WRR_LOCK_EN
        lock      = '0;
`endif
        seq1      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq2_idx  = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2};
        seq2_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset values, and ready is ignored while nothing is granted.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_valid", 32'(gnt_valid), 32'h0);
        checkOutput("rst_idx", 32'(gnt_idx), 32'h0);
        checkOutput("rst_last", 32'(gnt_last), 32'h0);
        rst = 1'b0;
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        checkOutput("idle_ready_valid", 32'(gnt_valid), 32'h0);

        // Plain round robin, weight 0 everywhere.
        doReset();
        applyStimulus(4'b1111, 16'h0000, 1'b1);
        checkOutput("rr_latency_valid", 32'(gnt_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 16'h0000, 1'b1);
            checkOutput($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(seq1[k]));
            checkOutput($sformatf("rr_last%0d", k), 32'(gnt_last), 32'h1);
            checkOutput($sformatf("rr_valid%0d", k), 32'(gnt_valid), 32'h1);
        end

        // Weighted: requester 0 weight 2 (3 grants), requester 2 weight 0.
        doReset();
        applyStimulus(4'b0101, 16'h0002, 1'b1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0101, 16'h0002, 1'b1);
            checkOutput($sformatf("wrr_idx%0d", k), 32'(gnt_idx), 32'(seq2_idx[k]));
            checkOutput($sformatf("wrr_last%0d", k), 32'(gnt_last), 32'(seq2_last[k]));
        end

        // Backpressure: weight 1 so gnt_last reveals exactly one accept.
        doReset();
        applyStimulus(4'b0010, 16'h0010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0010, 16'h0010, 1'b0);
            checkOutput($sformatf("bp_gnt%0d", k), 32'(gnt), 32'h2);
            checkOutput($sformatf("bp_last%0d", k), 32'(gnt_last), 32'h0);
        end
        applyStimulus(4'b0010, 16'h0010, 1'b1);
        checkOutput("bp_gnt5", 32'(gnt), 32'h2);
        checkOutput("bp_idx5", 32'(gnt_idx), 32'h1);
        applyStimulus(4'b0010, 16'h0010, 1'b0);
        checkOutput("bp_after_idx", 32'(gnt_idx), 32'h1);
        checkOutput("bp_after_last", 32'(gnt_last), 32'h1);

        // Early release: requester 1 weight 3 drops after its first accept.
        doReset();
        applyStimulus(4'b1010, 16'h0030, 1'b1);
        applyStimulus(4'b1010, 16'h0030, 1'b1);
        checkOutput("er_idx1", 32'(gnt_idx), 32'h1);
        checkOutput("er_last1", 32'(gnt_last), 32'h0);
        applyStimulus(4'b1001, 16'h0030, 1'b1);
        checkOutput("er_idx2", 32'(gnt_idx), 32'h1);
        checkOutput("er_last2", 32'(gnt_last), 32'h1);
        applyStimulus(4'b1001, 16'h0030, 1'b0);
        checkOutput("er_next_idx", 32'(gnt_idx), 32'h3);

        // Reset mid-burst with ptr moved to 3 and credit 2.
        doReset();
        applyStimulus(4'b1100, 16'h2000, 1'b1);
        applyStimulus(4'b1100, 16'h2000, 1'b1);
        checkOutput("mr_first_idx", 32'(gnt_idx), 32'h2);
        applyStimulus(4'b1100, 16'h2000, 1'b0);
        checkOutput("mr_burst_idx", 32'(gnt_idx), 32'h3);
        checkOutput("mr_burst_last", 32'(gnt_last), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("mr_async_gnt", 32'(gnt), 32'h0);
        checkOutput("mr_async_valid", 32'(gnt_valid), 32'h0);
        applyStimulus(4'b1100, 16'h2000, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mr_release_valid", 32'(gnt_valid), 32'h0);
        applyStimulus(4'b1100, 16'h2000, 1'b0);
        checkOutput("mr_post_idx", 32'(gnt_idx), 32'h2);
        checkOutput("mr_post_gnt", 32'(gnt), 32'h4);

`ifdef WRR_LOCK_EN
        // Lock holds requester 3 for four accepts despite weight 0.
        doReset();
        lock = 4'b1000;
        applyStimulus(4'b1000, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1000, 16'h0000, 1'b1);
            checkOutput($sformatf("lk_idx%0d", k), 32'(gnt_idx), 32'h3);
            checkOutput($sformatf("lk_last%0d", k), 32'(gnt_last), 32'h0);
        end
        lock = 4'b0000;
        applyStimulus(4'b1000, 16'h0000, 1'b1);
        checkOutput("lk_rel_idx", 32'(gnt_idx), 32'h3);
        checkOutput("lk_rel_last", 32'(gnt_last), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
